// File: rtl/corelet_ctrl.sv
// corelet_ctrl: sequencer for one corelet run (weight load, kernel load, activations, execute, drain).
// Optional macro CORELET_CTRL_ACC_EN compiles in the ACC psum-accumulation phase before FIN.
module corelet_ctrl #(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int KIJ    = 9,
    parameter int NIJ    = 36,
    parameter int ADDR_W = 11,
    parameter int X_BASE = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ofifo_valid,
    output logic [1:0]        inst,
    output logic              l0_wr,
    output logic              l0_rd,
    output logic              xmem_cen,
    output logic [ADDR_W-1:0] xmem_addr,
    output logic              ofifo_rd,
    output logic              pmem_wen,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic              accum,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(row + col + NIJ * KIJ + 2);
    localparam int KW = $clog2(KIJ + 1);
    localparam int OW = $clog2(NIJ + 1);

    typedef enum logic [2:0] {
        IDLE, W_LD, K_LD, X_LD, EXEC, DRAIN,
`ifdef CORELET_CTRL_ACC_EN
        ACC,
`endif
        FIN
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [KW-1:0] kcnt;
    logic [OW-1:0] ocnt;

    // phase sequencing; in ACC kcnt/ocnt walk kernel-major within each output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            kcnt  <= '0;
            ocnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= W_LD;
                        cnt   <= '0;
                        kcnt  <= '0;
                        ocnt  <= '0;
                    end
                end
                W_LD: begin
                    if (cnt == CW'(row - 1)) begin
                        state <= K_LD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                K_LD: begin
                    if (cnt == CW'(row + col - 1)) begin
                        state <= X_LD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                X_LD: begin
                    if (cnt == CW'(NIJ - 1)) begin
                        state <= EXEC;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                EXEC: begin
                    if (cnt == CW'(NIJ - 1)) begin
                        state <= DRAIN;
                        cnt   <= '0;
                        ocnt  <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    if (ofifo_valid) begin
                        if (ocnt == OW'(NIJ - 1)) begin
                            ocnt <= '0;
                            cnt  <= '0;
                            if (kcnt == KW'(KIJ - 1)) begin
`ifdef CORELET_CTRL_ACC_EN
                                state <= ACC;
                                kcnt  <= '0;
`else
                                state <= FIN;
`endif
                            end else begin
                                kcnt  <= kcnt + KW'(1);
                                state <= W_LD;
                            end
                        end else begin
                            ocnt <= ocnt + OW'(1);
                        end
                    end
                end
`ifdef CORELET_CTRL_ACC_EN
                ACC: begin
                    if (cnt == CW'(NIJ * KIJ)) begin
                        state <= FIN;
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (kcnt == KW'(KIJ - 1)) begin
                            kcnt <= '0;
                            ocnt <= ocnt + OW'(1);
                        end else begin
                            kcnt <= kcnt + KW'(1);
                        end
                    end
                end
`endif
                FIN: begin
                    state <= IDLE;
                    cnt   <= '0;
                    kcnt  <= '0;
                    ocnt  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // strobes that trail an SRAM read by one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            l0_wr <= 1'b0;
        end else begin
            l0_wr <= (state == W_LD) || (state == X_LD);
        end
    end

`ifdef CORELET_CTRL_ACC_EN
    // SFU accumulate follows each psum read; the flush cycle catches the last one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            accum <= 1'b0;
        end else begin
            accum <= (state == ACC) && (cnt < CW'(NIJ * KIJ));
        end
    end
`else
    assign accum = 1'b0;
`endif

    assign busy = (state != IDLE);

    // per-state strobe and address decode
    always_comb begin
        inst      = 2'b00;
        l0_rd     = 1'b0;
        xmem_cen  = 1'b1;
        xmem_addr = '0;
        ofifo_rd  = 1'b0;
        pmem_wen  = 1'b1;
        pmem_addr = '0;
        done      = 1'b0;
        case (state)
            W_LD: begin
                xmem_cen  = 1'b0;
                xmem_addr = ADDR_W'(int'(kcnt) * row + int'(cnt));
            end
            K_LD: begin
                inst  = 2'b01;
                l0_rd = (cnt < CW'(row));
            end
            X_LD: begin
                xmem_cen  = 1'b0;
                xmem_addr = ADDR_W'(X_BASE + int'(cnt));
            end
            EXEC: begin
                inst  = 2'b10;
                l0_rd = 1'b1;
            end
            DRAIN: begin
                ofifo_rd  = ofifo_valid;
                pmem_wen  = ~ofifo_valid;
                pmem_addr = ADDR_W'(int'(kcnt) * NIJ + int'(ocnt));
            end
`ifdef CORELET_CTRL_ACC_EN
            ACC: begin
                if (cnt < CW'(NIJ * KIJ)) begin
                    pmem_addr = ADDR_W'(int'(kcnt) * NIJ + int'(ocnt));
                end
            end
`endif
            FIN: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl: randomized run-level model of the corelet sequencer.
// Builds with or without CORELET_CTRL_ACC_EN.
module tb_corelet_ctrl;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int KIJ = 3;
    localparam int NIJ = 4;
    localparam int AW  = 11;
    localparam int XB  = 1024;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          ofifo_valid = 1'b0;
    logic [1:0]    inst;
    logic          l0_wr, l0_rd, xmem_cen, ofifo_rd, pmem_wen, accum, busy, done;
    logic [AW-1:0] xmem_addr, pmem_addr;

    corelet_ctrl #(
        .row(ROW), .col(COL), .KIJ(KIJ), .NIJ(NIJ), .ADDR_W(AW), .X_BASE(XB)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
        .inst(inst), .l0_wr(l0_wr), .l0_rd(l0_rd),
        .xmem_cen(xmem_cen), .xmem_addr(xmem_addr),
        .ofifo_rd(ofifo_rd), .pmem_wen(pmem_wen), .pmem_addr(pmem_addr),
        .accum(accum), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    inst;
        logic          l0rd, cen;
        logic [AW-1:0] xa;
        logic          ofrd, pwen, pchk;
        logic [AW-1:0] pa;
        logic          xrd, accrd, busy, done;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_xrd = 1'b0;
    logic prev_acc = 1'b0;
    logic rand_start = 1'b0;
    logic [AW-1:0] pop_seen[$];
    logic [AW-1:0] acc_seen[$];

    int c_kld = 0, c_exec = 0, c_wrd = 0, c_xrd = 0;
    int c_pop = 0, c_done = 0, c_acc = 0;

    // free-running observation counters
    always @(negedge clk) begin
        if (inst == 2'b01) c_kld++;
        if (inst == 2'b10) c_exec++;
        if (!xmem_cen && xmem_addr <  AW'(XB)) c_wrd++;
        if (!xmem_cen && xmem_addr >= AW'(XB)) c_xrd++;
        if (ofifo_rd) c_pop++;
        if (done) c_done++;
        if (accum) c_acc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d at %0t",
                         name, act, exp, $time);
        end
    endtask

    function automatic exp_t base(input logic b);
        exp_t e;
        e = '{inst: 2'b00, l0rd: 1'b0, cen: 1'b1, xa: '0, ofrd: 1'b0,
              pwen: 1'b1, pchk: 1'b0, pa: '0, xrd: 1'b0, accrd: 1'b0,
              busy: b, done: 1'b0};
        return e;
    endfunction

    function automatic logic rbit();
        return 1'($urandom % 2);
    endfunction

    // one clock cycle: apply ofifo_valid, compare at negedge, advance
    task automatic tick(input logic v, input exp_t e);
        ofifo_valid = v;
        @(negedge clk);
        check("inst", inst, e.inst);
        check("l0_rd", l0_rd, e.l0rd);
        check("l0_wr", l0_wr, prev_xrd);
        check("xmem_cen", xmem_cen, e.cen);
        if (!e.cen) check("xmem_addr", xmem_addr, e.xa);
        check("ofifo_rd", ofifo_rd, e.ofrd);
        check("pmem_wen", pmem_wen, e.pwen);
        if (e.pchk) check("pmem_addr", pmem_addr, e.pa);
        check("accum", accum, prev_acc);
        check("busy", busy, e.busy);
        check("done", done, e.done);
        if (e.ofrd) pop_seen.push_back(pmem_addr);
        if (e.accrd) acc_seen.push_back(pmem_addr);
        prev_xrd = e.xrd;
        prev_acc = e.accrd;
        @(posedge clk);
        #1;
        start = rand_start ? rbit() : 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_inst"}, inst, 2'b00);
        check({tag, "_l0_wr"}, l0_wr, 1'b0);
        check({tag, "_l0_rd"}, l0_rd, 1'b0);
        check({tag, "_xmem_cen"}, xmem_cen, 1'b1);
        check({tag, "_xmem_addr"}, xmem_addr, 0);
        check({tag, "_ofifo_rd"}, ofifo_rd, 1'b0);
        check({tag, "_pmem_wen"}, pmem_wen, 1'b1);
        check({tag, "_pmem_addr"}, pmem_addr, 0);
        check({tag, "_accum"}, accum, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
    endtask

    // called at EXEC cnt=2: reset drops between clock edges
    task automatic do_abort();
        exp_t e;
        rand_start = 1'b0;
        start = 1'b0;
        ofifo_valid = 1'b1;
        #2;
        check("pre_abort_busy", busy, 1'b1);
        check("pre_abort_inst", inst, 2'b10);
        reset = 1'b0;
        #1;
        check_reset_vals("abort");
        prev_xrd = 1'b0;
        prev_acc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("abort_hold_busy", busy, 1'b0);
        start = 1'b0;
        reset = 1'b1;
        e = base(1'b0);
        tick(rbit(), e);
        tick(rbit(), e);
    endtask

    // mode 0: valid always high; 1: 10-cycle stall in first DRAIN; 2: random
    task automatic run(input int mode, input bit abort);
        exp_t e;
        int   pops, stall;
        logic v;
        rand_start = 1'b1;
        start = 1'b1;
        tick(rbit(), base(1'b0));
        for (int k = 0; k < KIJ; k++) begin
            for (int i = 0; i < ROW; i++) begin
                e = base(1'b1);
                e.cen = 1'b0;
                e.xa = AW'(k * ROW + i);
                e.xrd = 1'b1;
                tick(rbit(), e);
            end
            for (int i = 0; i < ROW + COL; i++) begin
                e = base(1'b1);
                e.inst = 2'b01;
                e.l0rd = (i < ROW);
                tick(rbit(), e);
            end
            for (int i = 0; i < NIJ; i++) begin
                e = base(1'b1);
                e.cen = 1'b0;
                e.xa = AW'(XB + i);
                e.xrd = 1'b1;
                tick(rbit(), e);
            end
            for (int i = 0; i < NIJ; i++) begin
                if (abort && k == 0 && i == 2) begin
                    do_abort();
                    return;
                end
                e = base(1'b1);
                e.inst = 2'b10;
                e.l0rd = 1'b1;
                tick(rbit(), e);
            end
            pops = 0;
            stall = 0;
            while (pops < NIJ) begin
                if (mode == 0) v = 1'b1;
                else if (mode == 1) v = (k == 0 && stall < 10) ? 1'b0 : 1'b1;
                else v = (stall >= 50) ? 1'b1 : rbit();
                if (!v) stall++;
                e = base(1'b1);
                e.ofrd = v;
                e.pwen = ~v;
                e.pchk = v;
                e.pa = AW'(k * NIJ + pops);
                tick(v, e);
                if (v) pops++;
            end
        end
`ifdef CORELET_CTRL_ACC_EN
        for (int o = 0; o < NIJ; o++) begin
            for (int k = 0; k < KIJ; k++) begin
                e = base(1'b1);
                e.pchk = 1'b1;
                e.pa = AW'(k * NIJ + o);
                e.accrd = 1'b1;
                tick(rbit(), e);
            end
        end
        tick(rbit(), base(1'b1));
`endif
        rand_start = 1'b0;
        e = base(1'b1);
        e.done = 1'b1;
        tick(rbit(), e);
        tick(rbit(), base(1'b0));
    endtask

    int s_kld, s_exec, s_wrd, s_xrd, s_pop, s_done, s_acc;
    int exp_acc_order[6] = '{0, 4, 8, 1, 5, 9};

    initial begin
        #2;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset = 1'b1;
        tick(1'b0, base(1'b0));
        tick(1'b1, base(1'b0));

        s_kld = c_kld; s_exec = c_exec; s_wrd = c_wrd; s_xrd = c_xrd;
        s_pop = c_pop; s_done = c_done; s_acc = c_acc;
        pop_seen.delete();
        acc_seen.delete();
        run(0, 1'b0);
        check("cnt_kld", c_kld - s_kld, 16 * KIJ);
        check("cnt_exec", c_exec - s_exec, 4 * KIJ);
        check("cnt_wld", c_wrd - s_wrd, 8 * KIJ);
        check("cnt_xld", c_xrd - s_xrd, 4 * KIJ);
        check("cnt_pops", c_pop - s_pop, 12);
        check("cnt_done", c_done - s_done, 1);
        check("pop_count", pop_seen.size(), 12);
        for (int i = 0; i < pop_seen.size(); i++)
            check("pop_addr", pop_seen[i], i);
`ifdef CORELET_CTRL_ACC_EN
        check("cnt_accum", c_acc - s_acc, 12);
        check("acc_count", acc_seen.size(), 12);
        for (int i = 0; i < 6 && i < acc_seen.size(); i++)
            check("acc_order", acc_seen[i], exp_acc_order[i]);
`else
        check("cnt_accum", c_acc - s_acc, 0);
        check("acc_count", acc_seen.size(), 0);
`endif

        run(1, 1'b0);
        run(2, 1'b1);
        run(2, 1'b0);
        s_done = c_done;
        for (int r = 0; r < 3; r++) run(2, 1'b0);
        check("cnt_done_rand", c_done - s_done, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/corelet_ctrl.md
CORELET_CTRL -- requirements
Module: corelet_ctrl

Interface
REQ-001 SHALL have parameter row, default 8, PE rows and L0 depth per kernel load.
REQ-002 SHALL have parameter KIJ, default 9, kernel positions per run.
REQ-003 SHALL have parameter NIJ, default 36, activation vectors per kernel position.
REQ-004 SHALL have parameter ADDR_W, default 11, SRAM address width.
REQ-005 SHALL have parameter X_BASE, default 1024, activation region base in xmem.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, one-cycle run request, sampled only in IDLE.
REQ-009 SHALL have port ofifo_valid, input, 1, OFIFO holds a complete psum row.
REQ-010 SHALL have port inst, output, 2, MAC array instruction: bit1 execute, bit0 kernel load.
REQ-011 SHALL have ports l0_wr and l0_rd, outputs, 1 each, L0 write and read strobes.
REQ-012 SHALL have ports xmem_cen and xmem_addr, outputs, 1 and ADDR_W, xmem read enable (active-low) and address.
REQ-013 SHALL have ports ofifo_rd and pmem_wen, outputs, 1 each, OFIFO pop and psum write enable (active-low).
REQ-014 SHALL have ports pmem_addr and accum, outputs, ADDR_W and 1, psum address and SFU accumulate strobe.
REQ-015 SHALL have ports busy and done, outputs, 1 each: busy high outside IDLE; done is a one-cycle pulse at run end.

Function
REQ-016 SHALL implement states IDLE, W_LD, K_LD, X_LD, EXEC, DRAIN, ACC, FIN, with an internal phase counter cnt and kernel counter kcnt.
REQ-017 IDLE: all strobes inactive, inst=00; start=1 goes to W_LD with cnt=0, kcnt=0.
REQ-018 W_LD: row cycles; xmem_cen=0, xmem_addr=kcnt*row+cnt, l0_wr=1 one cycle after each read (SRAM latency 1); then K_LD.
REQ-019 K_LD: row+col cycles; l0_rd=1 for the first row cycles, inst=01 for all row+col cycles; then X_LD.
REQ-020 X_LD: NIJ cycles; xmem_addr=X_BASE+cnt, l0_wr delayed by one cycle; then EXEC.
REQ-021 EXEC: NIJ cycles; l0_rd=1, inst=10; then DRAIN.
REQ-022 DRAIN: ofifo_rd=ofifo_valid; each pop SHALL assert pmem_wen=0 on the same cycle with pmem_addr=kcnt*NIJ+ocnt, where ocnt counts pops 0..NIJ-1.
REQ-023 DRAIN SHALL exit only after NIJ pops; ofifo_valid low SHALL stall DRAIN indefinitely without a timeout.
REQ-024 After DRAIN: kcnt<KIJ-1 increments kcnt and returns to W_LD; kcnt=KIJ-1 proceeds to ACC (or FIN, per REQ-031).
REQ-025 ACC: for each output o in 0..NIJ-1 and kernel position k in 0..KIJ-1, pmem_addr=k*NIJ+o, pmem_wen=1, accum=1 one cycle after the read; NIJ*KIJ read cycles plus one flush cycle.
REQ-026 FIN: done=1 for exactly one cycle, then IDLE.
REQ-027 start asserted while busy=1 SHALL be ignored, not queued.
REQ-028 Counters SHALL wrap only through explicit reset in the state transitions, never by overflow; address arithmetic SHALL be truncated to ADDR_W.

Reset
REQ-029 reset=0 SHALL immediately force IDLE, clear cnt, kcnt, ocnt and all delay registers, drive inst=00, l0_wr=l0_rd=ofifo_rd=accum=busy=done=0, xmem_cen=pmem_wen=1, addresses 0.
REQ-030 Reset asserted mid-run SHALL abandon the run; after release, the block SHALL wait for a new start.

Configuration
REQ-031 Macro CORELET_CTRL_ACC_EN: defined, the ACC state is compiled in per REQ-025; undefined, ACC is absent, accum is tied 0, and the last DRAIN goes directly to FIN.

Verification
REQ-032 With row=8, KIJ=1, NIJ=4, and ofifo_valid held 1, a start pulse SHALL give W_LD 8, K_LD 16, X_LD 4, EXEC 4, and 4 pops to pmem addresses 0..3.
REQ-033 With ofifo_valid held 0 for 10 cycles in DRAIN, the bench SHALL see ofifo_rd=0 and pmem_wen=1 throughout, then the pops resume to the correct addresses.
REQ-034 With KIJ=3, NIJ=4 and ACC_EN defined, the ACC reads SHALL follow the address order 0,4,8,1,5,9,... with accum lagging by one cycle; done SHALL pulse once.
REQ-035 With reset driven low during EXEC at cnt=2, all outputs SHALL reach reset values asynchronously, and a later start SHALL rerun from kcnt=0.
REQ-036 With ACC_EN undefined, the last DRAIN SHALL be followed directly by done, and accum SHALL never assert; a start during busy SHALL have no effect.
